// File: rtl/lenet_pkg.sv
// Shared types and constants for the LeNet pooling datapath.
//   DATA_WIDTH      : pixel width in bits
//   IMAGE_WIDTH_DEF : default maximum line length
//   pixel_t         : signed pixel
//   pool_state_t    : max-pool sequencing states
package lenet_pkg;

    localparam int unsigned DATA_WIDTH      = 8;
    localparam int unsigned IMAGE_WIDTH_DEF = 28;

    typedef logic signed [DATA_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_ROW = 2'd1,
        ODD_ROW  = 2'd2
    } pool_state_t;

    // Signed maximum of two pixels.
    function automatic pixel_t max2(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream style pixel channel.
//   tvalid/tready : handshake, transfer when both high
//   tdata         : pixel
//   tuser         : start of frame
//   tlast         : end of line
interface axis_if #(
    parameter int unsigned DW = lenet_pkg::DATA_WIDTH
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tuser;
    logic          tlast;

    modport main       (output tvalid, tdata, tuser, tlast, input  tready);
    modport peripheral (input  tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/bram.sv
// Simple dual-port RAM with registered, enable-gated read (1-cycle latency).
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata updates only when re is high and then holds
//   rdata        : read data
module bram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 14,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Contents are always written before being read, so no reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/max_pool.sv
// Non-overlapping 2x2 signed max pooling, stride 2, on an AXI-Stream pixel stream.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   image_in  : input pixels (tuser = start of frame, tlast = end of line)
//   image_out : pooled pixels, registered, same tuser/tlast meaning
module max_pool
    import lenet_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH = IMAGE_WIDTH_DEF,
    parameter int unsigned POOL_SIZE   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    axis_if.peripheral    image_in,
    axis_if.main          image_out
);

    localparam int unsigned DEPTH = IMAGE_WIDTH / POOL_SIZE;
    localparam int unsigned SPAN  = DEPTH * 2;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(IMAGE_WIDTH + 1);
    localparam int unsigned PW    = $clog2(DEPTH + 1);

    pool_state_t   state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic          pair_q, pair_d;
    pixel_t        first_q, first_d;
    logic [PW-1:0] pairs_q, pairs_d;   // complete pairs written by the current even row
    logic          sof_q, sof_d;       // next output is the first of the frame
    pixel_t        dout_q, dout_d;
    logic          vld_q, vld_d;
    logic          user_q, user_d;
    logic          last_q, last_d;

    logic              accept, restart, active, in_span, pair_eff;
    pool_state_t       st_eff;
    logic [CW-1:0]     col_eff;
    logic [PW-1:0]     pairs_eff, idx_p;
    logic [AW-1:0]     idx_a;
    pixel_t            pix, m2, m3;
    logic              we_c, re_c;
    logic [DATA_WIDTH-1:0] rdata;

    assign image_in.tready  = !vld_q | image_out.tready;
    assign image_out.tvalid = vld_q;
    assign image_out.tdata  = dout_q;
    assign image_out.tuser  = user_q;
    assign image_out.tlast  = last_q;

    bram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_row_buf (
        .clk   (clk),
        .we    (we_c),
        .waddr (idx_a),
        .wdata (m2),
        .re    (re_c),
        .raddr (idx_a),
        .rdata (rdata)
    );

    // A tuser pixel is processed as row 0, column 0 regardless of current state.
    always_comb begin
        accept    = image_in.tvalid & image_in.tready;
        restart   = accept & image_in.tuser;
        active    = accept & (restart | (state_q != IDLE));
        pix       = pixel_t'(image_in.tdata);
        st_eff    = restart ? EVEN_ROW : state_q;
        col_eff   = restart ? '0 : col_q;
        pair_eff  = restart ? 1'b0 : pair_q;
        pairs_eff = restart ? '0 : pairs_q;
        in_span   = col_eff < CW'(SPAN);
        idx_a     = AW'(col_eff >> 1);
        idx_p     = PW'(col_eff >> 1);
        m2        = max2(first_q, pix);
        m3        = max2(m2, pixel_t'(rdata));
    end

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        pair_d  = pair_q;
        first_d = first_q;
        pairs_d = pairs_q;
        sof_d   = sof_q;
        dout_d  = dout_q;
        vld_d   = vld_q & ~image_out.tready;
        user_d  = user_q;
        last_d  = last_q;
        we_c    = 1'b0;
        re_c    = 1'b0;

        if (active) begin
            if (restart) sof_d = 1'b1;
            state_d = st_eff;
            pair_d  = pair_eff;
            pairs_d = pairs_eff;
            // Saturate so overlong lines never wrap the buffer address.
            col_d   = (col_eff == CW'(IMAGE_WIDTH)) ? col_eff : col_eff + CW'(1);

            if (in_span) begin
                if (!pair_eff) begin
                    // Read early so data is ready whenever the partner pixel arrives.
                    first_d = pix;
                    pair_d  = 1'b1;
                    re_c    = 1'b1;
                end else begin
                    pair_d = 1'b0;
                    if (st_eff == EVEN_ROW) begin
                        we_c    = 1'b1;
                        pairs_d = idx_p + PW'(1);
                    end else if (idx_p < pairs_eff) begin
                        // The even row's pair count tells us which pair ends the line,
                        // even when a trailing unpaired pixel carries the input tlast.
                        vld_d  = 1'b1;
                        dout_d = m3;
                        user_d = sof_q;
                        sof_d  = 1'b0;
                        last_d = image_in.tlast | (idx_p == pairs_eff - PW'(1));
                    end
                end
            end

            if (image_in.tlast) begin
                col_d   = '0;
                pair_d  = 1'b0;
                state_d = (st_eff == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                if (st_eff == ODD_ROW) pairs_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            pair_q  <= 1'b0;
            first_q <= '0;
            pairs_q <= '0;
            sof_q   <= 1'b0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            pair_q  <= pair_d;
            first_q <= first_d;
            pairs_q <= pairs_d;
            sof_q   <= sof_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            user_q  <= user_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: doc/max_pool.md
MAX_POOL -- requirements
Module: max_pool

Interface
REQ-001 Parameter IMAGE_WIDTH, default 28: maximum input pixels per line; legal range 2..64.
REQ-002 Parameter POOL_SIZE, default 2: pooling window edge; only the value 2 is supported.
REQ-003 clock  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 image_in  axis_if.peripheral  8-bit tdata  convolution output stream:
- signed 8-bit tdata
- tuser = start of frame (first pixel)
- tlast = end of line
REQ-006 image_out  axis_if.main  8-bit tdata  pooled stream, same tuser/tlast semantics.

Function
REQ-007 The block SHALL perform non-overlapping 2x2 max pooling (signed compare), stride 2, on each frame.
REQ-008 Input transfer SHALL occur when image_in.tvalid & image_in.tready.
REQ-009 Output transfer SHALL occur when image_out.tvalid & image_out.tready.
REQ-010 State machine SHALL have states IDLE, EVEN_ROW, ODD_ROW.
- IDLE -> EVEN_ROW on accepted tuser.
- EVEN_ROW -> ODD_ROW on accepted tlast.
- ODD_ROW -> EVEN_ROW on accepted tlast.
REQ-011 In IDLE, non-tuser input SHALL be accepted (tready=1) and discarded.
REQ-012 An accepted tuser in any state SHALL restart the frame:
- column counter = 0, row parity = even
- that pixel is processed as row 0, column 0
- no partial output is emitted.
REQ-013 A column counter SHALL count accepted pixels in the line and clear on accepted tlast.
REQ-014 A pair flag SHALL mark the first (even column) and second (odd column) pixel of each horizontal pair.
REQ-015 EVEN_ROW: on each second pixel, max(first, second) SHALL be written to the row buffer at address column/2.
REQ-016 ODD_ROW: on each second pixel, the block SHALL compute max(first, second, rowbuf[column/2]) and load it into the output register.
REQ-017 Output timing and flags:
- image_out.tvalid asserts the cycle after that acceptance (latency 1).
- Output tuser SHALL be 1 on the first output of the frame only.
- Output tlast SHALL be 1 on the output produced by the line's final complete pair.
REQ-018 Odd line length: the trailing unpaired pixel SHALL be discarded, and the last complete pair carries output tlast.
REQ-019 Odd row count: the trailing unpaired row SHALL be discarded silently.
REQ-020 image_in.tready SHALL equal !image_out.tvalid | image_out.tready.
- No input is lost under backpressure.
- Throughput is 1 pixel/cycle when downstream is ready.
REQ-021 Output held under backpressure: tdata, tuser and tlast SHALL remain stable while tvalid=1 and tready=0.
REQ-022 A line longer than IMAGE_WIDTH SHALL saturate the column counter, with no writes beyond IMAGE_WIDTH/2-1 and no address wrap.
REQ-023 The row-buffer read address SHALL be issued on the first pixel of a pair so that read data is valid when the second pixel is accepted, independent of stall length.

Reset
REQ-024 On reset assertion, the following SHALL clear immediately, regardless of clock:
- state = IDLE
- column counter = 0
- pair flag = 0
- image_out.tvalid = 0, tuser = 0, tlast = 0, tdata = 0
REQ-025 Row buffer contents SHALL NOT require reset; they are always written before being read within a frame.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; after release the block waits in IDLE for tuser.

Structure
REQ-027 Package lenet_pkg SHALL hold:
- DATA_WIDTH = 8
- typedef pixel_t (signed 8-bit)
- default IMAGE_WIDTH
- the pool state enum
REQ-028 The row buffer SHALL be one instance of the existing bram module:
- WIDTH 8, DEPTH IMAGE_WIDTH/2
- 1-cycle read latency
REQ-029 Comparison and sequencing logic SHALL remain in max_pool; no further sub-modules.

Verification
REQ-030 4x4 frame, rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, tready=1 -> outputs 6,8,14,16:
- tuser on 6
- tlast on 8 and 16
- one-cycle latency
REQ-031 Signed data: row0 {-128,-1}, row1 {-5,-2} -> output -1.
REQ-032 Random image_out.tready at 30% duty on a 28x28 ramp frame -> 196 outputs matching the golden model, with no drop, duplicate or tdata change while stalled.
REQ-033 5x5 frame -> 2x2 output: column 4 and row 4 are discarded, and tlast is on the second output of each row.
REQ-034 tuser reasserted at row 1 column 3 of a frame -> no output from the aborted frame, and the new frame pools correctly from its first pixel.
REQ-035 reset pulled low while image_out.tvalid=1 -> tvalid=0 with no clock edge; after release, pixels before tuser are ignored.
